// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
// Registered up/down Gray-code counter with parallel load and a choice of
// wrap-around or saturating ends. Both the binary count and its Gray
// encoding are presented, together with a per-cycle mask of the Gray bits
// that changed. This makes it usable as a glitch-free pointer source for
// CDC and FIFO logic.
//
// Parameters
//   WIDTH    : counter width in bits (>= 2)
//   SATURATE : 0 = wrap at the ends, 1 = hold at the end value
//   INIT     : binary value taken on reset
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   en       in   count enable
//   up       in   direction, 1 = increment, 0 = decrement
//   load     in   parallel load strobe (has priority over en)
//   load_bin in   binary value to load
//   gray     out  Gray code of the current count
//   bin      out  binary count
//   chg      out  gray XOR previous gray
//   wrap     out  one-cycle pulse on roll-over in either direction
//   at_end   out  count sits at the end of the range in the current direction
// -----------------------------------------------------------------------------
module gray_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter bit          SATURATE = 1'b0,
   parameter int unsigned INIT     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] chg,
   output logic             wrap,
   output logic             at_end
);

   localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
   localparam logic [WIDTH-1:0] MAX_BIN   = '1;
   localparam logic [WIDTH-1:0] MIN_BIN   = '0;

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic [WIDTH-1:0] r_chg;
   logic             r_wrap;
   logic             r_at_end;

   logic [WIDTH-1:0] w_bin_nxt;
   logic [WIDTH-1:0] w_gray_nxt;
   logic [WIDTH-1:0] w_chg_nxt;
   logic             w_wrap_nxt;
   logic             w_at_end_nxt;
   logic             w_at_end_rst;

   // Next-count selection: load beats count, count beats hold.
   always_comb begin
      w_bin_nxt  = r_bin;
      w_wrap_nxt = 1'b0;
      if (load) begin
         w_bin_nxt = load_bin;
      end else if (en) begin
         if (up) begin
            if (r_bin == MAX_BIN) begin
               // At the top: either roll over or stay put.
               if (!SATURATE) begin
                  w_bin_nxt  = MIN_BIN;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_bin_nxt = r_bin + WIDTH'(1);
            end
         end else begin
            if (r_bin == MIN_BIN) begin
               if (!SATURATE) begin
                  w_bin_nxt  = MAX_BIN;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_bin_nxt = r_bin - WIDTH'(1);
            end
         end
      end
      w_gray_nxt   = w_bin_nxt ^ (w_bin_nxt >> 1);
      // Hold and saturation leave gray unchanged, so the mask is zero there.
      w_chg_nxt    = r_gray ^ w_gray_nxt;
      w_at_end_nxt = up ? (w_bin_nxt == MAX_BIN) : (w_bin_nxt == MIN_BIN);
      w_at_end_rst = up ? (INIT_BIN == MAX_BIN) : (INIT_BIN == MIN_BIN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bin    <= INIT_BIN;
         r_gray   <= INIT_GRAY;
         r_chg    <= '0;
         r_wrap   <= 1'b0;
         r_at_end <= w_at_end_rst;
      end else begin
         r_bin    <= w_bin_nxt;
         r_gray   <= w_gray_nxt;
         r_chg    <= w_chg_nxt;
         r_wrap   <= w_wrap_nxt;
         r_at_end <= w_at_end_nxt;
      end
   end

   assign bin    = r_bin;
   assign gray   = r_gray;
   assign chg    = r_chg;
   assign wrap   = r_wrap;
   assign at_end = r_at_end;

   // Gray output must always be the encoding of the binary count.
   a_gray_matches_bin: assert property (@(posedge clk) disable iff (!rst_n)
      r_gray == (r_bin ^ (r_bin >> 1)));

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised, registered Gray-code counter. It is the sequential successor to the team's 4-bit combinational binary-to-Gray converter.
- Keeps an internal binary count and presents it in both Gray and binary form.
- Supports up/down counting, parallel load, and either wrap or saturate at the ends of the range.
- Provides a per-cycle changed-bit mask, intended as a glitch-free pointer source for clock-domain-crossing and FIFO logic.

Parameters:
- WIDTH, 4: counter width in bits. Must be at least 2.
- SATURATE, 0: end-of-range mode. 0 = wrap around at the ends; 1 = hold at the end value.
- INIT, 0: binary value loaded on reset. Range 0 to 2^WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Synchronous, active-low.
- en  in  1  count enable.
- up  in  1  direction. 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_bin  in  WIDTH  binary value to load.
- gray  out  WIDTH  registered Gray code of the current count.
- bin  out  WIDTH  registered binary count.
- chg  out  WIDTH  registered mask: gray XOR previous gray.
- wrap  out  1  registered one-cycle pulse when the count rolls over in either direction.
- at_end  out  1  registered level. 1 when bin is all-ones while up=1, or all-zeros while up=0.

Behaviour:
- Everything is sampled on the rising edge of clk. All outputs are registered, so an input change is visible one cycle later.
- Priority per edge: reset, then load, then en, then hold.
- Reset (rst_n=0 at an edge):
  - bin = INIT, gray = INIT ^ (INIT>>1).
  - chg = 0, wrap = 0.
  - at_end is computed from INIT and the current up input.
  - Reset wins over load and en in the same cycle. Asserting reset mid-count aborts the count immediately at that edge.
- Load (load=1):
  - bin = load_bin, gray = load_bin ^ (load_bin>>1).
  - chg = old gray ^ new gray. More than one bit may be set.
  - wrap = 0.
  - en is ignored in that cycle.
- Count (en=1, load=0):
  - Next binary value is bin+1 when up=1 and bin-1 when up=0, computed modulo 2^WIDTH.
  - gray = next ^ (next>>1). chg has exactly one bit set.
  - SATURATE=0: stepping up from all-ones gives 0; stepping down from 0 gives all-ones. Either case sets wrap=1 for one cycle.
  - SATURATE=1: a step that would cross the end leaves bin and gray unchanged, with chg=0 and wrap=0.
- Hold (en=0, load=0): bin and gray keep their values, chg=0, wrap=0.
- at_end is recomputed every cycle from the next bin value and the current up input. It is never a pulse.
- Invariant: gray always equals bin ^ (bin>>1). Checked by assertion every cycle.
- Changing up while en=1 takes effect on the same edge. There is no extra latency for a direction change.

Test Plan:
- Reset: WIDTH=4, INIT=0, hold rst_n=0 for 2 cycles then release. Expect bin=0000, gray=0000, chg=0000, wrap=0.
- Count up: en=1, up=1 for 4 cycles from 0. Expect bin=0100, gray=0110. On the step to 0101, expect gray=0111 and chg=0001.
- Wrap up: load 1111, then en=1, up=1 for 1 cycle. Expect bin=0000, gray=0000, chg=1000, wrap=1 for exactly one cycle.
- Wrap down: from bin=0000, step with up=0. Expect bin=1111, gray=1000, chg=1000, wrap=1.
- Saturate: with SATURATE=1, load 1111, then en=1, up=1 for 3 cycles. Expect bin=1111, gray=1000, chg=0000, wrap=0, at_end=1 throughout.
- Load priority and mid-run reset:
  - load=1 with load_bin=1001 and en=1 on the same edge. Expect bin=1001, gray=1101, and no count step that cycle.
  - Then drop rst_n to 0 while en=1. Expect bin and gray to return to INIT at the next edge.
